// File: rtl/blink_decoder.sv
// Receive-side blink decoder: synchronises and debounces a 1-bit blink input,
// measures each high/low phase in clock cycles and flags a stable blink rate.
module blink_decoder #(
    parameter int CNT_W      = 24,
    parameter int DEB_CYCLES = 4,
    parameter int TOL        = 2,
    parameter int LOCK_N     = 4
) (
    input  logic             system1000,
    input  logic             system1000_rst,
    input  logic             led_i,
    output logic             level_o,
    output logic [CNT_W-1:0] half_period_o,
    output logic             period_valid_o,
    output logic             locked_o,
    output logic             timeout_o
);

    localparam int DW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);
    localparam int MW = (LOCK_N < 2) ? 1 : $clog2(LOCK_N + 1);

    localparam logic [DW-1:0]    DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [MW-1:0]    LOCK_LAST = MW'(LOCK_N - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_PRE   = CNT_MAX - CNT_W'(1);
    localparam logic [CNT_W-1:0] TOL_C     = CNT_W'(TOL);

    typedef enum logic [1:0] {
        HUNT,
        TRACK,
        LOCKED
    } state_t;

    logic [1:0]       sync_q;
    logic [DW-1:0]    deb_cnt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] prev;
    logic [MW-1:0]    match;
    logic             armed;
    state_t           state;

    logic             toggle;
    logic             meas_valid;
    logic             timeout_rise;
    logic [CNT_W-1:0] diff;
    logic             is_match;

    // The debounced level flips on the clock where the last differing sample lands;
    // that same edge closes the phase measured by cnt.
    assign toggle       = (sync_q[1] != level_o) && (deb_cnt == DEB_LAST);
    assign meas_valid   = toggle && armed && !timeout_o;
    assign timeout_rise = !toggle && !timeout_o && (cnt >= CNT_PRE);
    assign diff         = (cnt > prev) ? (cnt - prev) : (prev - cnt);
    assign is_match     = (diff <= TOL_C);

    // NOTE: non-blocking assignments make sync_q a genuine two-stage shift register.
    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            sync_q  <= 2'b00;
            deb_cnt <= '0;
            level_o <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], led_i};
            if (toggle) begin
                level_o <= ~level_o;
                deb_cnt <= '0;
            end else if (sync_q[1] != level_o) begin
                deb_cnt <= deb_cnt + DW'(1);
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            cnt       <= '0;
            timeout_o <= 1'b0;
        end else if (toggle) begin
            cnt       <= CNT_W'(1);
            timeout_o <= 1'b0;
        end else begin
            if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (cnt >= CNT_PRE) begin
                timeout_o <= 1'b1;
            end
        end
    end

    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            state          <= HUNT;
            prev           <= '0;
            match          <= '0;
            armed          <= 1'b0;
            half_period_o  <= '0;
            period_valid_o <= 1'b0;
            locked_o       <= 1'b0;
        end else begin
            period_valid_o <= meas_valid;
            if (toggle) begin
                armed <= 1'b1;
            end

            if (timeout_rise) begin
                // A stalled input invalidates everything learned so far.
                state    <= HUNT;
                match    <= '0;
                locked_o <= 1'b0;
                armed    <= 1'b0;
            end else if (meas_valid) begin
                half_period_o <= cnt;
                prev          <= cnt;
                case (state)
                    HUNT: begin
                        match <= '0;
                        state <= TRACK;
                    end
                    TRACK: begin
                        if (is_match) begin
                            match <= match + MW'(1);
                            if (match == LOCK_LAST) begin
                                state    <= LOCKED;
                                locked_o <= 1'b1;
                            end
                        end else begin
                            match <= '0;
                        end
                    end
                    LOCKED: begin
                        if (!is_match) begin
                            state    <= TRACK;
                            match    <= '0;
                            locked_o <= 1'b0;
                        end
                    end
                    default: begin
                        state    <= HUNT;
                        match    <= '0;
                        locked_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_blink_decoder.sv
// Directed bench for blink_decoder: reset, debounce latency, lock/unlock,
// timeout recovery and asynchronous reset mid-phase.
module tb_blink_decoder;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             led = 1'b0;
    logic             level_o;
    logic [CNT_W-1:0] half_period_o;
    logic             period_valid_o;
    logic             locked_o;
    logic             timeout_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int   len;
        logic val;
        bit   exp_pulse;
        int   exp_hp;
        bit   exp_lk;
    } phase_vec_t;

    phase_vec_t vecs[10];

    blink_decoder #(
        .CNT_W(CNT_W),
        .DEB_CYCLES(3),
        .TOL(1),
        .LOCK_N(3)
    ) dut (
        .system1000(clk),
        .system1000_rst(rst),
        .led_i(led),
        .level_o(level_o),
        .half_period_o(half_period_o),
        .period_valid_o(period_valid_o),
        .locked_o(locked_o),
        .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one phase; any measurement pulse must land 5 cycles into it.
    task automatic phase(input int len, input logic val, input bit exp_pulse,
                         input int exp_hp, input bit exp_lk, input string tag);
        int pulses = 0;
        led = val;
        for (int i = 1; i <= len; i++) begin
            step();
            if (period_valid_o) begin
                pulses++;
                check({tag, " pulse_step"}, 32'(i), 32'd5);
                check({tag, " half_period"}, 32'(half_period_o), 32'(exp_hp));
                check({tag, " locked_at_pulse"}, 32'(locked_o), 32'(exp_lk));
            end
        end
        check({tag, " pulse_count"}, 32'(pulses), exp_pulse ? 32'd1 : 32'd0);
        check({tag, " locked_end"}, 32'(locked_o), 32'(exp_lk));
    endtask

    initial begin
        vecs[0] = '{20, 1'b0, 1'b1, 20, 1'b0};
        vecs[1] = '{20, 1'b1, 1'b1, 20, 1'b0};
        vecs[2] = '{20, 1'b0, 1'b1, 20, 1'b0};
        vecs[3] = '{21, 1'b1, 1'b1, 20, 1'b1};
        vecs[4] = '{20, 1'b0, 1'b1, 21, 1'b1};
        vecs[5] = '{21, 1'b1, 1'b1, 20, 1'b1};
        vecs[6] = '{25, 1'b0, 1'b1, 21, 1'b1};
        vecs[7] = '{25, 1'b1, 1'b1, 25, 1'b0};
        vecs[8] = '{25, 1'b0, 1'b1, 25, 1'b0};
        vecs[9] = '{25, 1'b1, 1'b1, 25, 1'b0};

        // Reset held with a toggling input: everything stays quiet.
        for (int i = 0; i < 10; i++) begin
            led = ~led;
            step();
            check("rst_outputs", {20'd0, level_o, period_valid_o, locked_o, timeout_o, half_period_o}, 32'd0);
        end
        led = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check("post_rst_quiet", {30'd0, level_o, period_valid_o}, 32'd0);
        end

        // Two-cycle glitch is rejected.
        led = 1'b1;
        step();
        step();
        led = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check("glitch_level", {30'd0, level_o, period_valid_o}, 32'd0);
        end

        // Clean rise: level follows 5 cycles later, first edge gives no pulse.
        led = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i <= 5) check("rise_latency", 32'(level_o), (i == 5) ? 32'd1 : 32'd0);
            check("first_edge_no_pulse", 32'(period_valid_o), 32'd0);
        end

        // Lock on a 20-cycle square wave, tolerate jitter, unlock and relock on 25.
        for (int v = 0; v < 10; v++) begin
            phase(vecs[v].len, vecs[v].val, vecs[v].exp_pulse, vecs[v].exp_hp,
                  vecs[v].exp_lk, $sformatf("vec%0d", v));
        end

        // Input stalls low: last 25 relocks, then the counter saturates.
        led = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            step();
            if (i == 5) begin
                check("stall_pulse", 32'(period_valid_o), 32'd1);
                check("stall_hp", 32'(half_period_o), 32'd25);
            end else begin
                check("stall_no_pulse", 32'(period_valid_o), 32'd0);
            end
            if (i >= 258 && i <= 260) begin
                check("timeout_rise", 32'(timeout_o), (i >= 259) ? 32'd1 : 32'd0);
                check("timeout_unlock", 32'(locked_o), (i >= 259) ? 32'd0 : 32'd1);
            end
        end
        check("timeout_held", 32'(timeout_o), 32'd1);
        check("timeout_locked", 32'(locked_o), 32'd0);

        // First edge after a timeout clears it without a measurement.
        led = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            check("post_timeout_no_pulse", 32'(period_valid_o), 32'd0);
            if (i <= 6) check("timeout_clear", 32'(timeout_o), (i < 5) ? 32'd1 : 32'd0);
        end
        phase(20, 1'b0, 1'b1, 20, 1'b0, "recover0");
        phase(20, 1'b1, 1'b1, 20, 1'b0, "recover1");
        phase(20, 1'b0, 1'b1, 20, 1'b0, "recover2");
        phase(20, 1'b1, 1'b1, 20, 1'b1, "recover3");

        // Asynchronous reset mid-phase while locked.
        phase(10, 1'b0, 1'b1, 20, 1'b1, "pre_rst");
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", {20'd0, level_o, period_valid_o, locked_o, timeout_o, half_period_o}, 32'd0);
        step();
        step();
        check("async_rst_held", {20'd0, level_o, period_valid_o, locked_o, timeout_o, half_period_o}, 32'd0);
        rst = 1'b0;
        phase(10, 1'b0, 1'b0, 0, 1'b0, "relock_idle");
        phase(20, 1'b1, 1'b0, 0, 1'b0, "relock_first");
        phase(20, 1'b0, 1'b1, 20, 1'b0, "relock0");
        phase(20, 1'b1, 1'b1, 20, 1'b0, "relock1");
        phase(20, 1'b0, 1'b1, 20, 1'b0, "relock2");
        phase(20, 1'b1, 1'b1, 20, 1'b1, "relock3");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
